bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_pkg.sv | 13 +
 rtl/bcd_adj3.sv | 11 +
 rtl/bin2bcd_seq.sv | 101 ++++++++++
 tb/tb_bin2bcd_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and default sizes for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int DEF_BIN_W  = 10;
    localparam int DEF_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_adj3 (
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock, MSB first.
// Latency: done pulses BIN_W+1 cycles after the accepting edge; bcd is registered.
// Backpressure: start only accepted while ready (IDLE); requests in CONV/DONE are dropped.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t            state;
    state_t            state_nxt;
    logic [BIN_W-1:0]  shift_q;
    logic [BCD_W-1:0]  work_q;
    logic [BCD_W-1:0]  work_adj;
    logic [BCD_W-1:0]  work_shf;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_bit;
    logic              accept;
    logic              unused_top_bit;

    // All digits are corrected in parallel on the pre-shift value.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_adj3 u_adj (
            .digit (work_q[4*d +: 4]),
            .adj   (work_adj[4*d +: 4])
        );
    end

    assign work_shf       = {work_adj[BCD_W-2:0], shift_q[BIN_W-1]};
    assign unused_top_bit = work_adj[BCD_W-1];
    assign last_bit       = (cnt_q == CNT_W'(1));
    assign accept         = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd     <= '0;
        end else if (accept) begin
            shift_q <= bin_in;
            work_q  <= '0;
            cnt_q   <= CNT_W'(BIN_W);
        end else if (state == CONV) begin
            shift_q <= {shift_q[BIN_W-2:0], 1'b0};
            work_q  <= work_shf;
            cnt_q   <= cnt_q - CNT_W'(1);
            // Publish only the final shifted value so bcd stays stable otherwise.
            if (last_bit) begin
                bcd <= work_shf;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, corner sequences, sweep and random values.
module tb_bin2bcd_seq;

    localparam int BIN_W  = 10;
    localparam int DIGITS = 4;
    localparam int LAT    = BIN_W + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  bin_in;
    logic        ready;
    logic        done;
    logic [15:0] bcd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bin_in (bin_in),
        .ready  (ready),
        .done   (done),
        .bcd    (bcd)
    );

    typedef struct {
        logic [9:0]  bin;
        logic [15:0] exp;
    } vec_t;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Must be entered at a negedge with the DUT idle; returns at the negedge after done.
    task automatic run_conv(input logic [9:0] v, output logic [15:0] res, output int lat,
                            output bit hold_ok, output logic extra_done);
        logic [15:0] held;
        held    = bcd;
        hold_ok = 1'b1;
        chk("ready_before_start", 32'(ready), 32'd1);
        bin_in = v;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 10'($urandom);
        lat    = 1;
        while (!done && lat < 40) begin
            if (bcd !== held) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
            bin_in = 10'($urandom);
        end
        res = bcd;
        @(negedge clk);
        extra_done = done;
    endtask

    // Scripted 16-cycle conversion with optional input change, extra start pulses and reset.
    task automatic conv_seq(input logic [9:0] v, input int chg_cyc, input logic [9:0] chg_val,
                            input int p1, input int p2, input int rst_cyc,
                            output logic [15:0] res, output int first_done, output int n_done,
                            output logic rdy_after_rst, output logic [15:0] bcd_after_rst);
        first_done    = -1;
        n_done        = 0;
        res           = 'x;
        rdy_after_rst = 1'b0;
        bcd_after_rst = 'x;
        bin_in = v;
        start  = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 16; c++) begin
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = c;
                    res        = bcd;
                end
            end
            if (c == rst_cyc + 1) begin
                rdy_after_rst = ready;
                bcd_after_rst = bcd;
            end
            start = (c == p1) || (c == p2);
            rst   = (c == rst_cyc);
            if (c == chg_cyc) bin_in = chg_val;
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    vec_t        vecs[8];
    logic [15:0] res;
    logic [15:0] bcd_r;
    int          lat;
    int          first_done;
    int          n_done;
    bit          hold_ok;
    logic        extra;
    logic        rdy_r;
    int          done_cyc[$];
    logic [9:0]  rv;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        vecs[0] = '{10'd0,    16'h0000};
        vecs[1] = '{10'd89,   16'h0089};
        vecs[2] = '{10'd610,  16'h0610};
        vecs[3] = '{10'd1023, 16'h1023};
        vecs[4] = '{10'd233,  16'h0233};
        vecs[5] = '{10'd144,  16'h0144};
        vecs[6] = '{10'd987,  16'h0987};
        vecs[7] = '{10'd5,    16'h0005};

        repeat (2) @(negedge clk);
        // Start is asserted alongside reset to confirm reset wins.
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done",  32'(done),  32'd0);
        chk("reset_bcd",   32'(bcd),   32'h0000);

        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].bin, res, lat, hold_ok, extra);
            chk($sformatf("vec%0d_bcd(%0d)", i, vecs[i].bin), 32'(res), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("vec%0d_single_done", i), 32'(extra), 32'd0);
            chk($sformatf("vec%0d_bcd_hold_idle", i), 32'(bcd), 32'(vecs[i].exp));
        end

        // Input changes to 5 during cycle 3 of converting 1023.
        conv_seq(10'd1023, 3, 10'd5, -1, -1, -1, res, first_done, n_done, rdy_r, bcd_r);
        chk("chg_input_bcd", 32'(res), 32'h1023);
        chk("chg_input_done_cycle", 32'(first_done), 32'(LAT));
        chk("chg_input_n_done", 32'(n_done), 32'd1);

        // Extra start pulses at cycles 4 and 11 of converting 233.
        conv_seq(10'd233, -1, 10'd0, 4, 11, -1, res, first_done, n_done, rdy_r, bcd_r);
        chk("restart_bcd", 32'(res), 32'h0233);
        chk("restart_done_cycle", 32'(first_done), 32'(LAT));
        chk("restart_n_done", 32'(n_done), 32'd1);
        chk("restart_idle_after", 32'(ready), 32'd1);

        // Reset during cycle 5 of converting 987.
        conv_seq(10'd987, -1, 10'd0, -1, -1, 5, res, first_done, n_done, rdy_r, bcd_r);
        chk("abort_n_done", 32'(n_done), 32'd0);
        chk("abort_ready_next", 32'(rdy_r), 32'd1);
        chk("abort_bcd_cleared", 32'(bcd_r), 32'h0000);
        chk("abort_bcd_later", 32'(bcd), 32'h0000);
        run_conv(10'd987, res, lat, hold_ok, extra);
        chk("after_abort_bcd", 32'(res), 32'h0987);
        chk("after_abort_latency", 32'(lat), 32'(LAT));

        // start held high: conversions back to back with one idle cycle between.
        bin_in = 10'd144;
        start  = 1'b1;
        done_cyc.delete();
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                done_cyc.push_back(c);
                chk($sformatf("held_bcd_c%0d", c), 32'(bcd), 32'h0144);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("held_n_done", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() == 3) begin
            chk("held_first", 32'(done_cyc[0]), 32'(LAT));
            chk("held_period1", 32'(done_cyc[1] - done_cyc[0]), 32'd12);
            chk("held_period2", 32'(done_cyc[2] - done_cyc[1]), 32'd12);
        end
        for (int w = 0; w < 30 && !ready; w++) @(negedge clk);
        chk("held_back_to_idle", 32'(ready), 32'd1);

        // Exhaustive sweep, then random values, against the arithmetic reference.
        for (int v = 0; v < 1024; v++) begin
            run_conv(10'(v), res, lat, hold_ok, extra);
            chk($sformatf("sweep_bcd(%0d)", v), 32'(res), 32'(ref_bcd(v)));
            chk($sformatf("sweep_latency(%0d)", v), 32'(lat), 32'(LAT));
            chk($sformatf("sweep_single_done(%0d)", v), 32'(extra), 32'd0);
            chk($sformatf("sweep_bcd_hold(%0d)", v), 32'(hold_ok), 32'd1);
        end
        for (int k = 0; k < 100; k++) begin
            rv = 10'($urandom);
            run_conv(rv, res, lat, hold_ok, extra);
            chk($sformatf("rand_bcd(%0d)", rv), 32'(res), 32'(ref_bcd(int'(rv))));
            chk($sformatf("rand_latency(%0d)", rv), 32'(lat), 32'(LAT));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
